// File: rtl/juego_pkg.sv
// Shared types and screen constants for the basket game object engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package juego_pkg;

  localparam int ANCHO_PANTALLA = 640;
  localparam int ALTO_PANTALLA  = 480;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    JUEGO  = 2'd1,
    FIN    = 2'd2
  } estado_t;

  // One falling object: position, speed (px/frame), worth, colour, occupancy
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] vel;
    logic [2:0] puntos;
    logic [7:0] color;
    logic       valido;
  } slot_t;

endpackage

// File: rtl/slot_objeto.sv
// One object slot: holds its record, advances per frame, flags catch/miss and pixel hit.
// Latency: slot state updates 1 cycle after load/advance; flags are combinational.
// Backpressure: none; loads are only issued by the top when the slot is free.
module slot_objeto
  import juego_pkg::*;
#(
  parameter int LADO          = 16,
  parameter int ANCHO_CANASTA = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_borrar,
  input  logic       i_cargar,
  input  logic [9:0] i_x,
  input  logic [1:0] i_velocidad,
  input  logic [7:0] i_color,
  input  logic       i_avanzar,
  input  logic [9:0] i_canasta_x,
  input  logic [8:0] i_canasta_y,
  input  logic [9:0] i_pixel_x,
  input  logic [9:0] i_pixel_y,
  output logic       o_valido,
  output logic [9:0] o_x,
  output logic [2:0] o_puntos,
  output logic [7:0] o_color,
  output logic       o_captura,
  output logic       o_fallo,
  output logic       o_impacto
);

  localparam logic [10:0] L_LADO    = 11'(LADO);
  localparam logic [10:0] L_CANASTA = 11'(ANCHO_CANASTA);
  localparam logic [10:0] L_ALTO    = 11'(ALTO_PANTALLA);

  slot_t       r_slot;
  logic [10:0] w_y_nuevo;
  logic [10:0] w_base_ant;
  logic [10:0] w_base_nueva;
  logic [10:0] w_canasta_y;
  logic        w_cruza;
  logic        w_solapa;
  logic        w_en_x;
  logic        w_en_y;

  // Geometry: bottom edge crossing the basket top, horizontal overlap, pixel cover
  always_comb begin
    w_y_nuevo    = {1'b0, r_slot.y} + {8'd0, r_slot.vel};
    w_base_ant   = {1'b0, r_slot.y} + L_LADO;
    w_base_nueva = w_y_nuevo + L_LADO;
    w_canasta_y  = {2'b00, i_canasta_y};
    w_cruza      = (w_base_ant < w_canasta_y) && (w_canasta_y <= w_base_nueva);
    w_solapa     = ({1'b0, r_slot.x} < ({1'b0, i_canasta_x} + L_CANASTA)) &&
                   ({1'b0, i_canasta_x} < ({1'b0, r_slot.x} + L_LADO));
    o_captura    = r_slot.valido && i_avanzar && w_cruza && w_solapa;
    // A catch takes precedence over reaching the floor in the same frame
    o_fallo      = r_slot.valido && i_avanzar && !(w_cruza && w_solapa) &&
                   (w_base_nueva >= L_ALTO);
    w_en_x       = (i_pixel_x >= r_slot.x) &&
                   ({1'b0, i_pixel_x} < ({1'b0, r_slot.x} + L_LADO));
    w_en_y       = (i_pixel_y >= r_slot.y) &&
                   ({1'b0, i_pixel_y} < ({1'b0, r_slot.y} + L_LADO));
    o_impacto    = r_slot.valido && w_en_x && w_en_y;
  end

  // Slot record: clear dominates, then load, then free on event, else advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot <= '0;
    end else if (i_borrar) begin
      r_slot <= '0;
    end else if (i_cargar) begin
      r_slot.x      <= i_x;
      r_slot.y      <= '0;
      r_slot.vel    <= {1'b0, i_velocidad} + 3'd1;
      r_slot.puntos <= {1'b0, i_velocidad} + 3'd1;
      r_slot.color  <= i_color;
      r_slot.valido <= 1'b1;
    end else if (o_captura || o_fallo) begin
      r_slot <= '0;
    end else if (i_avanzar && r_slot.valido) begin
      r_slot.y <= w_y_nuevo[9:0];
    end
  end

  assign o_valido = r_slot.valido;
  assign o_x      = r_slot.x;
  assign o_puntos = r_slot.puntos;
  assign o_color  = r_slot.color;

endmodule

// File: rtl/motor_objetos.sv
// Falling-object engine: FSM, spawn allocation, per-frame catch/miss scoring, pixel paint.
// Latency: activos/puntaje/pulses 1 cycle after tick; pintar/color_out 1 cycle after pixel.
// Backpressure: none; spawns with no free slot or horizontal overlap are dropped.
// Option: define MOTOR_PENALIZACION_EN to subtract 1 point per miss (floored at 0).
module motor_objetos
  import juego_pkg::*;
#(
  parameter int N_OBJ         = 5,
  parameter int LADO          = 16,
  parameter int ANCHO_CANASTA = 64,
  parameter int PUNTAJE_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 fin_juego,
  input  logic                 tick_spawn,
  input  logic                 tick_frame,
  input  logic [9:0]           x_aleatoria,
  input  logic [1:0]           velocidad_in,
  input  logic [7:0]           color_in,
  input  logic [9:0]           pos_x_canasta,
  input  logic [8:0]           pos_y_canasta,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  output logic                 pintar,
  output logic [7:0]           color_out,
  output logic [N_OBJ-1:0]     activos,
  output logic [PUNTAJE_W-1:0] puntaje,
  output logic                 pulso_captura,
  output logic                 pulso_fallo,
  output logic                 en_juego
);

  localparam logic [9:0]  X_MAX      = 10'(ANCHO_PANTALLA - LADO);
  localparam logic [9:0]  L_LADO     = 10'(LADO);
  localparam logic [31:0] PUNTAJE_MX = 32'((1 << PUNTAJE_W) - 1);

  estado_t r_estado, w_estado_sig;
  logic    w_entra_juego, w_borrar, w_frame, w_spawn;

  logic [N_OBJ-1:0] w_valido, w_captura, w_fallo, w_impacto, w_cargar;
  logic [9:0]       w_x      [N_OBJ];
  logic [2:0]       w_puntos [N_OBJ];
  logic [7:0]       w_color  [N_OBJ];

  logic [9:0]  w_x_nuevo;
  logic        w_libre_vld;
  logic [4:0]  w_libre_idx;
  logic        w_choque;
  logic [9:0]  w_dist;
  logic [31:0] w_suma;
  logic [31:0] w_puntaje_sig;
`ifdef MOTOR_PENALIZACION_EN
  logic [31:0] w_n_fallos;
`endif
  logic        w_pintar;
  logic [7:0]  w_color_px;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_estado <= REPOSO;
    else        r_estado <= w_estado_sig;
  end

  // FSM next state; start inside JUEGO is ignored
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      REPOSO:  if (start)     w_estado_sig = JUEGO;
      JUEGO:   if (fin_juego) w_estado_sig = FIN;
      FIN:     if (start)     w_estado_sig = JUEGO;
      default:                w_estado_sig = REPOSO;
    endcase
  end

  // FSM outputs: slot clearing on any state entry, gated spawn/frame strobes
  always_comb begin
    en_juego      = (r_estado == JUEGO);
    w_entra_juego = (r_estado != JUEGO) && start;
    w_borrar      = w_entra_juego || ((r_estado == JUEGO) && fin_juego);
    w_frame       = (r_estado == JUEGO) && tick_frame && !fin_juego;
    w_spawn       = (r_estado == JUEGO) && tick_spawn && !fin_juego;
  end

  // Spawn placement: clamp x, find lowest free slot, reject horizontal overlap
  always_comb begin
    w_x_nuevo   = (x_aleatoria > X_MAX) ? X_MAX : x_aleatoria;
    w_libre_vld = 1'b0;
    w_libre_idx = '0;
    w_choque    = 1'b0;
    w_dist      = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (!w_valido[i]) begin
        w_libre_vld = 1'b1;
        w_libre_idx = 5'(i);
      end
    end
    for (int k = 0; k < N_OBJ; k++) begin
      w_dist = (w_x_nuevo >= w_x[k]) ? (w_x_nuevo - w_x[k]) : (w_x[k] - w_x_nuevo);
      if (w_valido[k] && (w_dist < L_LADO)) w_choque = 1'b1;
    end
    for (int i = 0; i < N_OBJ; i++) begin
      w_cargar[i] = w_spawn && w_libre_vld && !w_choque && (w_libre_idx == 5'(i));
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_OBJ; g++) begin : g_slot
      slot_objeto #(
        .LADO          (LADO),
        .ANCHO_CANASTA (ANCHO_CANASTA)
      ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .i_borrar    (w_borrar),
        .i_cargar    (w_cargar[g]),
        .i_x         (w_x_nuevo),
        .i_velocidad (velocidad_in),
        .i_color     (color_in),
        .i_avanzar   (w_frame),
        .i_canasta_x (pos_x_canasta),
        .i_canasta_y (pos_y_canasta),
        .i_pixel_x   (pixel_x),
        .i_pixel_y   (pixel_y),
        .o_valido    (w_valido[g]),
        .o_x         (w_x[g]),
        .o_puntos    (w_puntos[g]),
        .o_color     (w_color[g]),
        .o_captura   (w_captura[g]),
        .o_fallo     (w_fallo[g]),
        .o_impacto   (w_impacto[g])
      );
    end
  endgenerate

  assign activos = w_valido;

  // Score: sum all catches this frame, saturate, then optional per-miss penalty
  always_comb begin
    w_suma = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (w_captura[i]) w_suma = w_suma + {29'd0, w_puntos[i]};
    end
    w_puntaje_sig = {{(32-PUNTAJE_W){1'b0}}, puntaje} + w_suma;
    if (w_puntaje_sig > PUNTAJE_MX) w_puntaje_sig = PUNTAJE_MX;
`ifdef MOTOR_PENALIZACION_EN
    w_n_fallos = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (w_fallo[i]) w_n_fallos = w_n_fallos + 32'd1;
    end
    w_puntaje_sig = (w_n_fallos > w_puntaje_sig) ? 32'd0 : (w_puntaje_sig - w_n_fallos);
`endif
  end

  // Score and event pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      puntaje       <= '0;
      pulso_captura <= 1'b0;
      pulso_fallo   <= 1'b0;
    end else begin
      pulso_captura <= w_frame && (|w_captura);
      pulso_fallo   <= w_frame && (|w_fallo);
      if (w_entra_juego)  puntaje <= '0;
      else if (w_frame)   puntaje <= w_puntaje_sig[PUNTAJE_W-1:0];
    end
  end

  // Pixel priority mux: lowest active index covering the pixel wins
  always_comb begin
    w_pintar   = 1'b0;
    w_color_px = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (w_impacto[i]) begin
        w_pintar   = 1'b1;
        w_color_px = w_color[i];
      end
    end
  end

  // Registered paint request and colour
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pintar    <= 1'b0;
      color_out <= '0;
    end else begin
      pintar    <= w_pintar;
      color_out <= w_color_px;
    end
  end

endmodule

// File: tb/tb_motor_objetos.sv
// Directed bench for motor_objetos: spawn, catch, miss, full, overlap, saturation, FSM.
// Latency: checks sample on negedge, one cycle after stimulus.
// Backpressure: n/a.
module tb_motor_objetos;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, fin_juego, tick_spawn, tick_frame;
  logic [9:0] x_aleatoria;
  logic [1:0] velocidad_in;
  logic [7:0] color_in;
  logic [9:0] pos_x_canasta;
  logic [8:0] pos_y_canasta;
  logic [9:0] pixel_x, pixel_y;

  logic       pintar, pulso_captura, pulso_fallo, en_juego;
  logic [7:0] color_out;
  logic [4:0] activos;
  logic [9:0] puntaje;

  logic       pintar2, pulso_captura2, pulso_fallo2, en_juego2;
  logic [7:0] color_out2;
  logic [4:0] activos2;
  logic [2:0] puntaje2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  motor_objetos #(.N_OBJ(5), .LADO(16), .ANCHO_CANASTA(64), .PUNTAJE_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .fin_juego(fin_juego),
    .tick_spawn(tick_spawn), .tick_frame(tick_frame), .x_aleatoria(x_aleatoria),
    .velocidad_in(velocidad_in), .color_in(color_in), .pos_x_canasta(pos_x_canasta),
    .pos_y_canasta(pos_y_canasta), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pintar(pintar), .color_out(color_out), .activos(activos), .puntaje(puntaje),
    .pulso_captura(pulso_captura), .pulso_fallo(pulso_fallo), .en_juego(en_juego)
  );

  motor_objetos #(.N_OBJ(5), .LADO(16), .ANCHO_CANASTA(64), .PUNTAJE_W(3)) dut_w3 (
    .clk(clk), .reset(reset), .start(start), .fin_juego(fin_juego),
    .tick_spawn(tick_spawn), .tick_frame(tick_frame), .x_aleatoria(x_aleatoria),
    .velocidad_in(velocidad_in), .color_in(color_in), .pos_x_canasta(pos_x_canasta),
    .pos_y_canasta(pos_y_canasta), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pintar(pintar2), .color_out(color_out2), .activos(activos2), .puntaje(puntaje2),
    .pulso_captura(pulso_captura2), .pulso_fallo(pulso_fallo2), .en_juego(en_juego2)
  );

  task automatic pulse(input logic p_start, input logic p_fin, input logic p_spawn, input logic p_frame);
    @(negedge clk);
    start = p_start; fin_juego = p_fin; tick_spawn = p_spawn; tick_frame = p_frame;
    @(negedge clk);
    start = 1'b0; fin_juego = 1'b0; tick_spawn = 1'b0; tick_frame = 1'b0;
  endtask

  task automatic spawn(input logic [9:0] x, input logic [1:0] v, input logic [7:0] c);
    x_aleatoria = x; velocidad_in = v; color_in = c;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic run_frames(input int n, output int eventos);
    eventos = 0;
    for (int i = 0; i < n; i++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      if (pulso_captura || pulso_fallo) eventos++;
    end
  endtask

  task automatic probe(input logic [9:0] px, input logic [9:0] py);
    @(negedge clk);
    pixel_x = px; pixel_y = py;
    @(negedge clk);
  endtask

  task automatic new_game();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; fin_juego = 0; tick_spawn = 0; tick_frame = 0;
    x_aleatoria = 0; velocidad_in = 0; color_in = 0;
    pos_x_canasta = 10'd80; pos_y_canasta = 9'd400; pixel_x = 10'd1000; pixel_y = 10'd1000;
    repeat (3) @(negedge clk);
    total++; if (activos !== 5'b0) begin bad++; $display("FAIL rst_activos got=%b exp=%b", activos, 5'b0); end
    total++; if (puntaje !== 10'd0) begin bad++; $display("FAIL rst_puntaje got=%0d exp=0", puntaje); end
    total++; if (pintar !== 1'b0 || color_out !== 8'h00) begin bad++; $display("FAIL rst_pixel got=%b/%h exp=0/00", pintar, color_out); end
    total++; if (pulso_captura !== 1'b0 || pulso_fallo !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b exp=00", pulso_captura, pulso_fallo); end
    total++; if (en_juego !== 1'b0) begin bad++; $display("FAIL rst_en_juego got=%b exp=0", en_juego); end
    reset = 1'b1;
    spawn(10'd50, 2'd0, 8'h01);
    total++; if (activos !== 5'b0) begin bad++; $display("FAIL idle_spawn got=%b exp=%b", activos, 5'b0); end
  endtask

  task automatic test_spawn();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (en_juego !== 1'b1) begin bad++; $display("FAIL start_en_juego got=%b exp=1", en_juego); end
    spawn(10'd700, 2'd1, 8'hA5);
    total++; if (activos !== 5'b00001) begin bad++; $display("FAIL spawn_activos got=%b exp=00001", activos); end
    probe(10'd624, 10'd0);
    total++; if (pintar !== 1'b1 || color_out !== 8'hA5) begin bad++; $display("FAIL spawn_px_corner got=%b/%h exp=1/a5", pintar, color_out); end
    probe(10'd623, 10'd0);
    total++; if (pintar !== 1'b0 || color_out !== 8'h00) begin bad++; $display("FAIL spawn_px_left got=%b/%h exp=0/00", pintar, color_out); end
    probe(10'd639, 10'd15);
    total++; if (pintar !== 1'b1) begin bad++; $display("FAIL spawn_px_far got=%b exp=1", pintar); end
    probe(10'd624, 10'd16);
    total++; if (pintar !== 1'b0) begin bad++; $display("FAIL spawn_px_below got=%b exp=0", pintar); end
  endtask

  task automatic test_catch();
    int ev;
    new_game();
    total++; if (activos !== 5'b0 || puntaje !== 10'd0) begin bad++; $display("FAIL newgame got=%b/%0d exp=00000/0", activos, puntaje); end
    pos_x_canasta = 10'd80; pos_y_canasta = 9'd400;
    spawn(10'd100, 2'd1, 8'h3C);
    run_frames(191, ev);
    total++; if (ev !== 0 || activos !== 5'b00001) begin bad++; $display("FAIL catch_pre got=%0d/%b exp=0/00001", ev, activos); end
    probe(10'd100, 10'd382);
    total++; if (pintar !== 1'b1 || color_out !== 8'h3C) begin bad++; $display("FAIL catch_y382 got=%b/%h exp=1/3c", pintar, color_out); end
    probe(10'd100, 10'd381);
    total++; if (pintar !== 1'b0) begin bad++; $display("FAIL catch_y381 got=%b exp=0", pintar); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (puntaje !== 10'd2) begin bad++; $display("FAIL catch_puntaje got=%0d exp=2", puntaje); end
    total++; if (pulso_captura !== 1'b1 || pulso_fallo !== 1'b0) begin bad++; $display("FAIL catch_pulses got=%b%b exp=10", pulso_captura, pulso_fallo); end
    total++; if (activos !== 5'b0) begin bad++; $display("FAIL catch_freed got=%b exp=00000", activos); end
    @(negedge clk);
    total++; if (pulso_captura !== 1'b0) begin bad++; $display("FAIL catch_pulse_width got=%b exp=0", pulso_captura); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (en_juego !== 1'b1 || puntaje !== 10'd2) begin bad++; $display("FAIL start_ignored got=%b/%0d exp=1/2", en_juego, puntaje); end
  endtask

  task automatic test_miss();
    int ev;
    logic [9:0] exp_p;
`ifdef MOTOR_PENALIZACION_EN
    exp_p = 10'd1;
`else
    exp_p = 10'd2;
`endif
    pos_x_canasta = 10'd300; pos_y_canasta = 9'd400;
    spawn(10'd100, 2'd1, 8'h3C);
    run_frames(231, ev);
    total++; if (ev !== 0 || activos !== 5'b00001) begin bad++; $display("FAIL miss_pre got=%0d/%b exp=0/00001", ev, activos); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (pulso_fallo !== 1'b1 || pulso_captura !== 1'b0) begin bad++; $display("FAIL miss_pulses got=%b%b exp=01", pulso_fallo, pulso_captura); end
    total++; if (activos !== 5'b0) begin bad++; $display("FAIL miss_freed got=%b exp=00000", activos); end
    total++; if (puntaje !== exp_p) begin bad++; $display("FAIL miss_puntaje got=%0d exp=%0d", puntaje, exp_p); end
  endtask

  task automatic test_full();
    new_game();
    for (int i = 0; i < 5; i++) spawn(10'(i * 100), 2'd0, 8'(8'h10 + i));
    total++; if (activos !== 5'b11111) begin bad++; $display("FAIL full_fill got=%b exp=11111", activos); end
    spawn(10'd500, 2'd0, 8'h77);
    total++; if (activos !== 5'b11111) begin bad++; $display("FAIL full_drop got=%b exp=11111", activos); end
    probe(10'd400, 10'd0);
    total++; if (pintar !== 1'b1 || color_out !== 8'h14) begin bad++; $display("FAIL full_px4 got=%b/%h exp=1/14", pintar, color_out); end
    probe(10'd500, 10'd0);
    total++; if (pintar !== 1'b0) begin bad++; $display("FAIL full_px_dropped got=%b exp=0", pintar); end
  endtask

  task automatic test_overlap();
    new_game();
    spawn(10'd200, 2'd0, 8'h01);
    total++; if (activos !== 5'b00001) begin bad++; $display("FAIL ovl_first got=%b exp=00001", activos); end
    spawn(10'd210, 2'd0, 8'h02);
    total++; if (activos !== 5'b00001) begin bad++; $display("FAIL ovl_210 got=%b exp=00001", activos); end
    spawn(10'd216, 2'd0, 8'h03);
    total++; if (activos !== 5'b00011) begin bad++; $display("FAIL ovl_216 got=%b exp=00011", activos); end
    spawn(10'd185, 2'd0, 8'h04);
    total++; if (activos !== 5'b00011) begin bad++; $display("FAIL ovl_185 got=%b exp=00011", activos); end
    spawn(10'd184, 2'd0, 8'h05);
    total++; if (activos !== 5'b00111) begin bad++; $display("FAIL ovl_184 got=%b exp=00111", activos); end
  endtask

  task automatic test_back_to_back();
    new_game();
    pos_x_canasta = 10'd80; pos_y_canasta = 9'd400;
    spawn(10'd0, 2'd0, 8'h21);
    x_aleatoria = 10'd300; velocidad_in = 2'd0; color_in = 8'h22;
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    total++; if (activos !== 5'b00011) begin bad++; $display("FAIL b2b_activos got=%b exp=00011", activos); end
    probe(10'd300, 10'd0);
    total++; if (pintar !== 1'b1 || color_out !== 8'h22) begin bad++; $display("FAIL b2b_new_y0 got=%b/%h exp=1/22", pintar, color_out); end
    probe(10'd0, 10'd0);
    total++; if (pintar !== 1'b0) begin bad++; $display("FAIL b2b_old_moved got=%b exp=0", pintar); end
    probe(10'd0, 10'd1);
    total++; if (pintar !== 1'b1 || color_out !== 8'h21) begin bad++; $display("FAIL b2b_old_y1 got=%b/%h exp=1/21", pintar, color_out); end
  endtask

  task automatic test_saturation();
    int ev;
    new_game();
    pos_x_canasta = 10'd80; pos_y_canasta = 9'd400;
    spawn(10'd80, 2'd3, 8'h31);
    spawn(10'd100, 2'd3, 8'h32);
    run_frames(95, ev);
    total++; if (ev !== 0 || activos !== 5'b00011) begin bad++; $display("FAIL sat_pre got=%0d/%b exp=0/00011", ev, activos); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (puntaje !== 10'd8) begin bad++; $display("FAIL sat_sum10 got=%0d exp=8", puntaje); end
    total++; if (puntaje2 !== 3'd7) begin bad++; $display("FAIL sat_w3 got=%0d exp=7", puntaje2); end
    total++; if (pulso_captura !== 1'b1 || activos !== 5'b0) begin bad++; $display("FAIL sat_event got=%b/%b exp=1/00000", pulso_captura, activos); end
    spawn(10'd0, 2'd0, 8'h40);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (en_juego !== 1'b0 || activos !== 5'b0) begin bad++; $display("FAIL fin_clear got=%b/%b exp=0/00000", en_juego, activos); end
    total++; if (puntaje !== 10'd8 || puntaje2 !== 3'd7) begin bad++; $display("FAIL fin_hold got=%0d/%0d exp=8/7", puntaje, puntaje2); end
    spawn(10'd0, 2'd0, 8'h40);
    total++; if (activos !== 5'b0) begin bad++; $display("FAIL fin_spawn got=%b exp=00000", activos); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (en_juego !== 1'b1 || puntaje !== 10'd0 || puntaje2 !== 3'd0) begin bad++; $display("FAIL restart got=%b/%0d/%0d exp=1/0/0", en_juego, puntaje, puntaje2); end
  endtask

  task automatic test_fin_frame();
    int ev;
    pos_x_canasta = 10'd80; pos_y_canasta = 9'd400;
    spawn(10'd80, 2'd3, 8'h50);
    run_frames(95, ev);
    total++; if (ev !== 0 || activos !== 5'b00001) begin bad++; $display("FAIL finfr_pre got=%0d/%b exp=0/00001", ev, activos); end
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    total++; if (puntaje !== 10'd0 || pulso_captura !== 1'b0) begin bad++; $display("FAIL finfr_score got=%0d/%b exp=0/0", puntaje, pulso_captura); end
    total++; if (activos !== 5'b0 || en_juego !== 1'b0) begin bad++; $display("FAIL finfr_state got=%b/%b exp=00000/0", activos, en_juego); end
  endtask

  task automatic test_async_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    spawn(10'd0, 2'd0, 8'h60);
    total++; if (activos !== 5'b00001 || en_juego !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b/%b exp=00001/1", activos, en_juego); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (activos !== 5'b0 || en_juego !== 1'b0) begin bad++; $display("FAIL arst_now got=%b/%b exp=00000/0", activos, en_juego); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_catch();
    test_miss();
    test_full();
    test_overlap();
    test_back_to_back();
    test_saturation();
    test_fin_frame();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
